// File: rtl/ov7670_cfg_seq.sv
// ov7670_cfg_seq
// Register-initialisation sequencer for the OV7670 camera. Walks a table of
// {reg_addr, data} entries held in an external synchronous ROM and issues one
// I2C write per entry through the master's i_wr/o_busy handshake. It also
// handles inline millisecond delays (reg 0xFF), NACK retries and the 0xFFFF
// end marker.
//
// Optional build macro: CFG_READBACK_EN
//   When defined, every NACK-free write is followed by a read of the same
//   register. The echo must match the written data, otherwise the entry is
//   retried. When undefined, o_rd is tied low and no read states exist.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_start                 1-cycle start pulse (ignored while o_busy)
//   o_busy/o_done/o_error   status; done and error are sticky
//   o_err_idx               ROM index of the failing entry
//   o_rom_addr/i_rom_data   ROM port, data valid one cycle after address
//   o_wr/o_rd               1-cycle requests to the I2C master
//   o_slave_addr            constant camera address
//   o_reg_addr/o_wdata      register address / data for the master
//   i_m_*                   master status, read data and NACK flags
module ov7670_cfg_seq #(
   parameter int         CLK_FREQ_HZ    = 100000000,
   parameter int         ROM_AW         = 8,
   parameter logic [6:0] SLAVE_ADDR     = 7'h21,
   parameter int         MAX_RETRY      = 3,
   parameter int         ACCEPT_TIMEOUT = 4096
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_error,
   output logic [ROM_AW-1:0] o_err_idx,
   output logic [ROM_AW-1:0] o_rom_addr,
   input  logic [15:0]       i_rom_data,
   output logic              o_wr,
   output logic              o_rd,
   output logic [6:0]        o_slave_addr,
   output logic [7:0]        o_reg_addr,
   output logic [7:0]        o_wdata,
   input  logic              i_m_busy,
   input  logic [7:0]        i_m_rdata,
   input  logic              i_m_rdata_valid,
   input  logic              i_m_nack_slave,
   input  logic              i_m_nack_addr,
   input  logic              i_m_nack_data
);

   localparam int                CYC_PER_MS = CLK_FREQ_HZ / 1000;
   localparam logic [31:0]       MS_LAST    = 32'(CYC_PER_MS - 1);
   localparam logic [31:0]       ACC_LAST   = 32'(ACCEPT_TIMEOUT - 1);
   localparam logic [7:0]        RETRY_MAX  = 8'(MAX_RETRY);
   localparam logic [ROM_AW-1:0] ADDR_LAST  = {ROM_AW{1'b1}};
   localparam logic [ROM_AW-1:0] ADDR_ONE   = {{(ROM_AW-1){1'b0}}, 1'b1};

`ifdef CFG_READBACK_EN
   typedef enum logic [3:0] {
      ST_IDLE, ST_FETCH, ST_DECODE, ST_ISSUE, ST_WAIT_ACCEPT, ST_WAIT_DONE,
      ST_DELAY, ST_NEXT, ST_DONE, ST_ERROR,
      ST_RB_ISSUE, ST_RB_WAIT_ACCEPT, ST_RB_WAIT_DONE
   } state_t;
`else
   typedef enum logic [3:0] {
      ST_IDLE, ST_FETCH, ST_DECODE, ST_ISSUE, ST_WAIT_ACCEPT, ST_WAIT_DONE,
      ST_DELAY, ST_NEXT, ST_DONE, ST_ERROR
   } state_t;
`endif

   state_t            state_r, state_s;
   logic              busy_s, done_s, error_s, wr_s, rd_s;
   logic [ROM_AW-1:0] err_idx_s, rom_addr_s;
   logic [7:0]        reg_addr_s, wdata_s;
   logic [7:0]        retry_r, retry_s;
   logic [7:0]        ms_r, ms_s;
   logic [31:0]       timer_r, timer_s;
   logic              nack_seen_r, nack_seen_s;
   logic              nack_any_s;
   logic              rd_r;

   assign nack_any_s   = i_m_nack_slave | i_m_nack_addr | i_m_nack_data;
   assign o_slave_addr = SLAVE_ADDR;

`ifdef CFG_READBACK_EN
   assign o_rd = rd_r;
`else
   logic rb_unused_s;
   assign rb_unused_s = ^{i_m_rdata, i_m_rdata_valid, rd_r};
   assign o_rd        = 1'b0;
`endif

   // Next-state and next-output computation for the sequencer FSM.
   always_comb begin
      state_s     = state_r;
      busy_s      = o_busy;
      done_s      = o_done;
      error_s     = o_error;
      err_idx_s   = o_err_idx;
      rom_addr_s  = o_rom_addr;
      reg_addr_s  = o_reg_addr;
      wdata_s     = o_wdata;
      wr_s        = 1'b0;
      rd_s        = 1'b0;
      retry_s     = retry_r;
      ms_s        = ms_r;
      timer_s     = timer_r;
      nack_seen_s = nack_seen_r;
      case (state_r)
         ST_IDLE: begin
            if (i_start) begin
               state_s    = ST_FETCH;
               busy_s     = 1'b1;
               rom_addr_s = {ROM_AW{1'b0}};
               done_s     = 1'b0;
               error_s    = 1'b0;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_FETCH: state_s = ST_DECODE;
         ST_DECODE: begin
            // End marker is checked first: 0xFFFF would otherwise decode as a delay.
            if (i_rom_data == 16'hFFFF) begin
               state_s = ST_DONE;
            end else if (i_rom_data[15:8] == 8'hFF) begin
               if (i_rom_data[7:0] == 8'h00) begin
                  state_s = ST_NEXT;
               end else begin
                  ms_s    = i_rom_data[7:0];
                  timer_s = 32'd0;
                  state_s = ST_DELAY;
               end
            end else begin
               reg_addr_s = i_rom_data[15:8];
               wdata_s    = i_rom_data[7:0];
               retry_s    = 8'd0;
               state_s    = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (!i_m_busy) begin
               wr_s        = 1'b1;
               timer_s     = 32'd0;
               nack_seen_s = 1'b0;
               state_s     = ST_WAIT_ACCEPT;
            end else begin
               state_s = ST_ISSUE;
            end
         end
         ST_WAIT_ACCEPT: begin
            if (i_m_busy) begin
               nack_seen_s = nack_seen_r | nack_any_s;
               state_s     = ST_WAIT_DONE;
            end else if (timer_r == ACC_LAST) begin
               state_s = ST_ERROR;
            end else begin
               timer_s = timer_r + 32'd1;
            end
         end
         ST_WAIT_DONE: begin
            // NACK flags clear together with busy, so capture them while busy is high.
            if (i_m_busy) begin
               nack_seen_s = nack_seen_r | nack_any_s;
            end else if (!nack_seen_r) begin
`ifdef CFG_READBACK_EN
               state_s = ST_RB_ISSUE;
`else
               state_s = ST_NEXT;
`endif
            end else if (retry_r < RETRY_MAX) begin
               retry_s = retry_r + 8'd1;
               state_s = ST_ISSUE;
            end else begin
               state_s = ST_ERROR;
            end
         end
`ifdef CFG_READBACK_EN
         ST_RB_ISSUE: begin
            if (!i_m_busy) begin
               rd_s        = 1'b1;
               timer_s     = 32'd0;
               nack_seen_s = 1'b0;
               state_s     = ST_RB_WAIT_ACCEPT;
            end else begin
               state_s = ST_RB_ISSUE;
            end
         end
         ST_RB_WAIT_ACCEPT: begin
            if (i_m_busy) begin
               nack_seen_s = nack_seen_r | nack_any_s;
               state_s     = ST_RB_WAIT_DONE;
            end else if (timer_r == ACC_LAST) begin
               state_s = ST_ERROR;
            end else begin
               timer_s = timer_r + 32'd1;
            end
         end
         ST_RB_WAIT_DONE: begin
            // A bad echo is treated like a NACK: the write is re-issued.
            if (i_m_busy) begin
               nack_seen_s = nack_seen_r | nack_any_s;
            end else if (!nack_seen_r && i_m_rdata_valid && (i_m_rdata == o_wdata)) begin
               state_s = ST_NEXT;
            end else if (retry_r < RETRY_MAX) begin
               retry_s = retry_r + 8'd1;
               state_s = ST_ISSUE;
            end else begin
               state_s = ST_ERROR;
            end
         end
`endif
         ST_DELAY: begin
            if (timer_r == MS_LAST) begin
               timer_s = 32'd0;
               if (ms_r == 8'd1) begin
                  state_s = ST_NEXT;
               end else begin
                  ms_s = ms_r - 8'd1;
               end
            end else begin
               timer_s = timer_r + 32'd1;
            end
         end
         ST_NEXT: begin
            // Running off the end of the ROM finishes the table instead of wrapping.
            if (o_rom_addr == ADDR_LAST) begin
               state_s = ST_DONE;
            end else begin
               rom_addr_s = o_rom_addr + ADDR_ONE;
               state_s    = ST_FETCH;
            end
         end
         ST_DONE: begin
            done_s  = 1'b1;
            busy_s  = 1'b0;
            state_s = ST_IDLE;
         end
         ST_ERROR: begin
            error_s   = 1'b1;
            err_idx_s = o_rom_addr;
            busy_s    = 1'b0;
            state_s   = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
            busy_s  = 1'b0;
         end
      endcase
   end

   // State, counter and output registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r     <= ST_IDLE;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_error     <= 1'b0;
         o_err_idx   <= {ROM_AW{1'b0}};
         o_rom_addr  <= {ROM_AW{1'b0}};
         o_wr        <= 1'b0;
         rd_r        <= 1'b0;
         o_reg_addr  <= 8'h00;
         o_wdata     <= 8'h00;
         retry_r     <= 8'd0;
         ms_r        <= 8'd0;
         timer_r     <= 32'd0;
         nack_seen_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         o_busy      <= busy_s;
         o_done      <= done_s;
         o_error     <= error_s;
         o_err_idx   <= err_idx_s;
         o_rom_addr  <= rom_addr_s;
         o_wr        <= wr_s;
         rd_r        <= rd_s;
         o_reg_addr  <= reg_addr_s;
         o_wdata     <= wdata_s;
         retry_r     <= retry_s;
         ms_r        <= ms_s;
         timer_r     <= timer_s;
         nack_seen_r <= nack_seen_s;
      end
   end

endmodule

// File: tb/tb_ov7670_cfg_seq.sv
// Testbench for ov7670_cfg_seq (default build, CFG_READBACK_EN undefined).
// DUT runs with 10 cycles/ms, a 16-entry ROM and a 16-cycle accept timeout.
// A behavioural I2C master answers writes with a random busy length and can
// NACK chosen entries; a table-walking reference model predicts the writes.
module tb_ov7670_cfg_seq;
   localparam int AW   = 4;
   localparam int NENT = 16;
   localparam int MAXR = 3;
   localparam int LIM  = 5000;

   logic          clk = 1'b0;
   logic          i_rst = 1'b1;
   logic          i_start = 1'b0;
   logic          o_busy, o_done, o_error, o_wr, o_rd;
   logic [AW-1:0] o_err_idx, o_rom_addr;
   logic [15:0]   i_rom_data = 16'h0000;
   logic [6:0]    o_slave_addr;
   logic [7:0]    o_reg_addr, o_wdata;
   logic          i_m_busy = 1'b1;
   logic [7:0]    i_m_rdata = 8'h00;
   logic          i_m_rdata_valid = 1'b0;
   logic          i_m_nack_slave = 1'b0, i_m_nack_addr = 1'b0, i_m_nack_data = 1'b0;

   int tests_run = 0, tests_failed = 0;
   int cyc = 0;
   logic [15:0] rom [NENT];

   // master model controls
   bit m_boot = 1'b1, m_accept = 1'b1, m_hang = 1'b0, m_abort = 1'b0;
   int nack_idx = -1, nack_limit = 0, nack_kind = 0;
   int m_cnt = 0, m_att = 0, m_last_idx = 0, att = 0, m_fall_cyc = 0;
   bit m_last_valid = 1'b0, m_nack_pend = 1'b0;

   // monitor
   logic [15:0] obs_q[$];
   int          gap_q[$];
   int          proto_err = 0, rd_cnt = 0;
   bit          wr_prev = 1'b0, busy_prev = 1'b0;
   logic [15:0] hold_pair = 16'h0000;

   // reference model results
   logic [15:0] exp_q[$];
   bit          exp_done, exp_err;
   int          exp_idx;

   ov7670_cfg_seq #(
      .CLK_FREQ_HZ(10000), .ROM_AW(AW), .SLAVE_ADDR(7'h21),
      .MAX_RETRY(MAXR), .ACCEPT_TIMEOUT(16)
   ) dut (
      .i_clk(clk), .i_rst(i_rst), .i_start(i_start),
      .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_err_idx(o_err_idx),
      .o_rom_addr(o_rom_addr), .i_rom_data(i_rom_data),
      .o_wr(o_wr), .o_rd(o_rd), .o_slave_addr(o_slave_addr),
      .o_reg_addr(o_reg_addr), .o_wdata(o_wdata),
      .i_m_busy(i_m_busy), .i_m_rdata(i_m_rdata), .i_m_rdata_valid(i_m_rdata_valid),
      .i_m_nack_slave(i_m_nack_slave), .i_m_nack_addr(i_m_nack_addr),
      .i_m_nack_data(i_m_nack_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // synchronous ROM: one cycle of read latency
   always @(posedge clk) i_rom_data <= rom[o_rom_addr];

   // behavioural I2C master
   always @(posedge clk) begin
      if (m_abort) begin
         m_cnt <= 0; i_m_busy <= 1'b0;
         i_m_nack_slave <= 1'b0; i_m_nack_addr <= 1'b0; i_m_nack_data <= 1'b0;
      end else if (m_cnt > 1) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 2 && m_nack_pend) begin
            case (nack_kind)
               0: i_m_nack_slave <= 1'b1;
               1: i_m_nack_addr  <= 1'b1;
               default: i_m_nack_data <= 1'b1;
            endcase
         end
      end else if (m_cnt == 1) begin
         m_cnt <= 0; i_m_busy <= 1'b0; m_fall_cyc <= cyc + 1;
         i_m_nack_slave <= 1'b0; i_m_nack_addr <= 1'b0; i_m_nack_data <= 1'b0;
      end else if (m_boot) begin
         i_m_busy <= 1'b1;
      end else if (o_wr && m_accept) begin
         i_m_busy <= 1'b1;
         m_cnt <= m_hang ? 100000 : int'($urandom_range(3, 8));
         att = (m_last_valid && int'(o_rom_addr) == m_last_idx) ? m_att + 1 : 0;
         m_att <= att;
         m_last_idx <= int'(o_rom_addr);
         m_last_valid <= 1'b1;
         m_nack_pend <= (int'(o_rom_addr) == nack_idx) && (att < nack_limit);
      end else begin
         i_m_busy <= 1'b0;
      end
      if (i_start && !o_busy) m_last_valid <= 1'b0;
   end

   // handshake monitor
   always @(negedge clk) begin
      if (o_wr) begin
         obs_q.push_back({o_reg_addr, o_wdata});
         gap_q.push_back(cyc - m_fall_cyc);
         hold_pair = {o_reg_addr, o_wdata};
         if (wr_prev) proto_err++;
         if (busy_prev) proto_err++;
      end else if (m_cnt != 0 && {o_reg_addr, o_wdata} !== hold_pair) begin
         proto_err++;
      end
      if (o_rd) rd_cnt++;
      wr_prev = o_wr;
      busy_prev = i_m_busy;
   end

   function automatic logic [15:0] obs_at(int i);
      if (i < obs_q.size()) return obs_q[i];
      return 16'hxxxx;
   endfunction

   // walk the table with the sequencer's rules and list the expected writes
   task automatic model_run();
      int nacks;
      logic [15:0] e;
      exp_q.delete(); exp_done = 1'b0; exp_err = 1'b0; exp_idx = 0;
      for (int idx = 0; idx < NENT; idx++) begin
         e = rom[idx];
         if (e == 16'hFFFF) begin exp_done = 1'b1; return; end
         if (e[15:8] == 8'hFF) continue;
         nacks = (idx == nack_idx) ? nack_limit : 0;
         for (int a = 0; a <= MAXR; a++) begin
            exp_q.push_back(e);
            if (a >= nacks) break;
            if (a == MAXR) begin exp_err = 1'b1; exp_idx = idx; return; end
         end
      end
      exp_done = 1'b1;
   endtask

   task automatic run_seq(input int boot_cycles, input bit restart,
                          output bit timed_out, output int boot_obs);
      int n;
      obs_q.delete(); gap_q.delete(); proto_err = 0; rd_cnt = 0;
      @(negedge clk); i_start = 1'b1;
      @(negedge clk); i_start = 1'b0;
      boot_obs = 0;
      if (boot_cycles > 0) begin
         repeat (boot_cycles) @(negedge clk);
         boot_obs = obs_q.size();
         m_boot = 1'b0;
      end
      n = 0;
      while (o_busy === 1'b1 && n < LIM) begin
         i_start = (restart && n == 10) ? 1'b1 : 1'b0;
         @(negedge clk); n++;
      end
      i_start = 1'b0;
      timed_out = (n >= LIM);
   endtask

   task automatic test_reset();
      for (int i = 0; i < NENT; i++) rom[i] = 16'hFFFF;
      i_rst = 1'b1;
      repeat (3) @(negedge clk);
      i_rst = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({o_busy, o_done, o_error, o_wr, o_rd} !== 5'b0) begin
         tests_failed++; $display("FAIL reset_flags got %b expected 00000", {o_busy, o_done, o_error, o_wr, o_rd});
      end
      tests_run++;
      if ({o_err_idx, o_rom_addr, o_reg_addr, o_wdata} !== 24'h0) begin
         tests_failed++; $display("FAIL reset_values got %h expected 0", {o_err_idx, o_rom_addr, o_reg_addr, o_wdata});
      end
      tests_run++;
      if (o_slave_addr !== 7'h21) begin
         tests_failed++; $display("FAIL slave_addr got %h expected 21", o_slave_addr);
      end
   endtask

   task automatic test_basic();
      bit to; int bo;
      rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'hFFFF;
      nack_idx = -1;
      run_seq(20, 1'b0, to, bo);
      tests_run++;
      if (to || bo != 0) begin
         tests_failed++; $display("FAIL basic_stall timeout=%0d writes_during_master_boot=%0d expected 0/0", to, bo);
      end
      tests_run++;
      if (obs_q.size() != 2) begin
         tests_failed++; $display("FAIL basic_count got %0d expected 2", obs_q.size());
      end
      tests_run++;
      if (obs_at(0) !== 16'h1280 || obs_at(1) !== 16'h1101) begin
         tests_failed++; $display("FAIL basic_data got %h %h expected 1280 1101", obs_at(0), obs_at(1));
      end
      tests_run++;
      if ({o_done, o_busy, o_error} !== 3'b100 || o_rom_addr !== 4'd2) begin
         tests_failed++; $display("FAIL basic_status got done/busy/err=%b addr=%0d expected 100 addr=2", {o_done, o_busy, o_error}, o_rom_addr);
      end
      tests_run++;
      if (proto_err != 0 || rd_cnt != 0) begin
         tests_failed++; $display("FAIL basic_protocol got proto_err=%0d rd=%0d expected 0 0", proto_err, rd_cnt);
      end
   endtask

   task automatic test_delay();
      bit to; int bo;
      rom[0] = 16'h1280; rom[1] = 16'hFF03; rom[2] = 16'h1101;
      rom[3] = 16'hFF00; rom[4] = 16'h1234; rom[5] = 16'hFFFF;
      run_seq(0, 1'b0, to, bo);
      tests_run++;
      if (to || obs_q.size() != 3 || obs_at(2) !== 16'h1234) begin
         tests_failed++; $display("FAIL delay_writes got count=%0d last=%h expected 3 1234", obs_q.size(), obs_at(2));
      end
      tests_run++;
      if (gap_q.size() < 3 || gap_q[1] < 36 || gap_q[1] > 46) begin
         tests_failed++; $display("FAIL delay_3ms_gap got %0d expected 36..46", (gap_q.size() > 1) ? gap_q[1] : -1);
      end
      tests_run++;
      if (gap_q.size() < 3 || gap_q[2] > 15) begin
         tests_failed++; $display("FAIL delay_0ms_gap got %0d expected <=15", (gap_q.size() > 2) ? gap_q[2] : -1);
      end
      tests_run++;
      if (o_done !== 1'b1 || o_error !== 1'b0) begin
         tests_failed++; $display("FAIL delay_done got done=%b err=%b expected 1 0", o_done, o_error);
      end
   endtask

   task automatic test_retry();
      bit to; int bo, cnt;
      rom[0] = 16'h1280; rom[1] = 16'h3A04; rom[2] = 16'h1101; rom[3] = 16'hFFFF;
      nack_idx = 1; nack_limit = 2; nack_kind = 1;
      run_seq(0, 1'b0, to, bo);
      cnt = 0;
      foreach (obs_q[i]) if (obs_q[i] == 16'h3A04) cnt++;
      tests_run++;
      if (cnt != 3 || obs_q.size() != 5) begin
         tests_failed++; $display("FAIL retry_count got 3A04x%0d total=%0d expected 3 5", cnt, obs_q.size());
      end
      tests_run++;
      if (to || o_done !== 1'b1 || o_error !== 1'b0) begin
         tests_failed++; $display("FAIL retry_done got done=%b err=%b expected 1 0", o_done, o_error);
      end
   endtask

   task automatic test_error();
      bit to; int bo, cnt;
      rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'h3A04; rom[3] = 16'h4455; rom[4] = 16'hFFFF;
      nack_idx = 2; nack_limit = 255; nack_kind = 0;
      run_seq(0, 1'b0, to, bo);
      cnt = 0;
      foreach (obs_q[i]) if (obs_q[i] == 16'h3A04) cnt++;
      tests_run++;
      if (cnt != 4 || obs_q.size() != 6) begin
         tests_failed++; $display("FAIL error_attempts got 3A04x%0d total=%0d expected 4 6", cnt, obs_q.size());
      end
      tests_run++;
      if (to || {o_error, o_done, o_busy} !== 3'b100 || o_err_idx !== 4'd2) begin
         tests_failed++; $display("FAIL error_status got err/done/busy=%b idx=%0d expected 100 idx=2", {o_error, o_done, o_busy}, o_err_idx);
      end
      nack_idx = -1;
   endtask

   task automatic test_timeout_reset();
      int n, w;
      rom[0] = 16'hFF00; rom[1] = 16'h1280; rom[2] = 16'hFFFF;
      m_accept = 1'b0;
      @(negedge clk); i_start = 1'b1;
      @(negedge clk); i_start = 1'b0;
      n = 0;
      while (o_wr !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      w = cyc;
      n = 0;
      while (o_error !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      tests_run++;
      if (cyc - w != 17) begin
         tests_failed++; $display("FAIL timeout_latency got %0d cycles expected 17", cyc - w);
      end
      tests_run++;
      if (o_err_idx !== 4'd1 || o_done !== 1'b0 || o_busy !== 1'b0) begin
         tests_failed++; $display("FAIL timeout_status got idx=%0d done=%b busy=%b expected 1 0 0", o_err_idx, o_done, o_busy);
      end
      // now reset while the master is mid-transaction
      m_accept = 1'b1; m_hang = 1'b1;
      @(negedge clk); i_start = 1'b1;
      @(negedge clk); i_start = 1'b0;
      n = 0;
      while (o_wr !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      repeat (3) @(negedge clk);
      tests_run++;
      if (o_busy !== 1'b1 || i_m_busy !== 1'b1 || o_reg_addr !== 8'h12) begin
         tests_failed++; $display("FAIL midtxn_state got busy=%b m_busy=%b reg=%h expected 1 1 12", o_busy, i_m_busy, o_reg_addr);
      end
      i_rst = 1'b1;
      @(negedge clk);
      tests_run++;
      if ({o_busy, o_done, o_error, o_wr, o_rd, o_err_idx, o_rom_addr, o_reg_addr, o_wdata} !== 29'h0) begin
         tests_failed++; $display("FAIL midtxn_reset got %h expected 0", {o_busy, o_done, o_error, o_wr, o_rd, o_err_idx, o_rom_addr, o_reg_addr, o_wdata});
      end
      i_rst = 1'b0; m_abort = 1'b1;
      @(negedge clk);
      m_abort = 1'b0; m_hang = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_full_table();
      bit to; int bo, bad;
      for (int i = 0; i < NENT; i++) rom[i] = {8'($urandom_range(0, 254)), 8'($urandom)};
      run_seq(0, 1'b0, to, bo);
      tests_run++;
      if (to || obs_q.size() != NENT) begin
         tests_failed++; $display("FAIL full_count got %0d expected %0d", obs_q.size(), NENT);
      end
      bad = 0;
      for (int i = 0; i < NENT; i++) if (obs_at(i) !== rom[i]) bad++;
      tests_run++;
      if (bad != 0) begin
         tests_failed++; $display("FAIL full_data got %0d wrong entries expected 0", bad);
      end
      tests_run++;
      if (o_done !== 1'b1 || o_error !== 1'b0 || o_rom_addr !== 4'd15) begin
         tests_failed++; $display("FAIL full_end got done=%b err=%b addr=%0d expected 1 0 15", o_done, o_error, o_rom_addr);
      end
   endtask

   task automatic test_random();
      bit to; int bo, len;
      for (int it = 0; it < 8; it++) begin
         len = $urandom_range(1, NENT);
         for (int i = 0; i < NENT; i++) begin
            if (i == len) rom[i] = 16'hFFFF;
            else if ($urandom_range(0, 4) == 0) rom[i] = 16'hFF00 | 16'($urandom_range(0, 2));
            else rom[i] = {8'($urandom_range(0, 254)), 8'($urandom)};
         end
         nack_idx = $urandom_range(0, NENT - 1);
         nack_limit = $urandom_range(0, 5);
         nack_kind = $urandom_range(0, 2);
         model_run();
         run_seq(0, 1'b1, to, bo);
         tests_run++;
         if (to || obs_q.size() != exp_q.size()) begin
            tests_failed++; $display("FAIL rand%0d_count got %0d expected %0d", it, obs_q.size(), exp_q.size());
         end
         for (int i = 0; i < exp_q.size(); i++) begin
            tests_run++;
            if (obs_at(i) !== exp_q[i]) begin
               tests_failed++; $display("FAIL rand%0d_write%0d got %h expected %h", it, i, obs_at(i), exp_q[i]);
            end
         end
         tests_run++;
         if (o_done !== exp_done || o_error !== exp_err || (exp_err && int'(o_err_idx) != exp_idx)) begin
            tests_failed++; $display("FAIL rand%0d_status got done=%b err=%b idx=%0d expected %b %b %0d", it, o_done, o_error, o_err_idx, exp_done, exp_err, exp_idx);
         end
         tests_run++;
         if (proto_err != 0 || rd_cnt != 0) begin
            tests_failed++; $display("FAIL rand%0d_protocol got proto_err=%0d rd=%0d expected 0 0", it, proto_err, rd_cnt);
         end
      end
      nack_idx = -1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_delay();
      test_retry();
      test_error();
      test_timeout_reset();
      test_full_table();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
